alu_pipe: RTL and testbench

Parametrised, pipelined successor to the combinational ALU in the ARM7 datapath. Accepts operand/opcode transactions over a valid/ready handshake, registers them through two stages, and returns a registered result with ARM-style NZCV flags. A persistent carry register feeds ADC/SBC, so multi-word arithmetic chains work back-to-back. It sits between the register-file read stage and writeback.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_core.sv | 57 +++++
 rtl/alu_pipe.sv | 77 +++++++
 tb/tb_alu_pipe.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encoding, NZCV flag indices and op-class helper for alu_pipe.
package alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0010,
    OP_ORR = 4'b0011,
    OP_EOR = 4'b0100,
    OP_ADC = 4'b0110,
    OP_SBC = 4'b0111,
    OP_LSL = 4'b1000,
    OP_LSR = 4'b1001,
    OP_ASR = 4'b1010,
    OP_MVN = 4'b1011,
    OP_ROR = 4'b1100
  } alu_op_e;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  function automatic logic is_arith(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_ADC, OP_SBC};
  endfunction
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU datapath with NZCV outputs; ROR is decoded only when ALU_ROR_EN is defined.
module alu_core import alu_pkg::*; #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  input  logic             c_in,
  output logic [WIDTH-1:0] result,
  output logic             n,
  output logic             z,
  output logic             c,
  output logic             v,
  output logic             illegal
);
  logic             sub;
  logic             cin;
  logic             ok;
  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   sum;
  logic [31:0]      amt;
`ifdef ALU_ROR_EN
  logic [31:0]      rot;
  logic [WIDTH-1:0] ror;
  assign rot = amt % WIDTH;
  assign ror = (a >> rot) | (a << (WIDTH - rot));
`endif
  assign sub = opcode inside {OP_SUB, OP_SBC};
  assign bx  = sub ? ~b : b;
  assign cin = opcode inside {OP_ADC, OP_SBC} ? c_in : sub;
  assign sum = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, cin};
  assign amt = 32'(b[SHAMT_W-1:0]);
  always_comb begin
    ok     = 1'b1;
    result = '0;
    case (opcode)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: result = sum[WIDTH-1:0];
      OP_AND: result = a & b;
      OP_ORR: result = a | b;
      OP_EOR: result = a ^ b;
      OP_MVN: result = ~a;
      OP_LSL: result = a << amt;
      OP_LSR: result = a >> amt;
      OP_ASR: result = $signed(a) >>> amt;
`ifdef ALU_ROR_EN
      OP_ROR: result = ror;
`endif
      default: ok = 1'b0;
    endcase
  end
  assign illegal = !ok;
  assign n       = result[WIDTH-1];
  assign z       = result == '0;
  assign c       = sum[WIDTH];
  assign v       = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU with persistent NZCV register (ROR via ALU_ROR_EN).
module alu_pipe import alu_pkg::*; #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             illegal
);
  logic             s1_valid;
  logic             s1_sf;
  logic             s2_ready;
  logic             arith;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [3:0]       s1_op;
  logic [WIDTH-1:0] c_res;
  logic             c_n;
  logic             c_z;
  logic             c_c;
  logic             c_v;
  logic             c_ill;
  assign s2_ready = !out_valid || out_ready;
  assign in_ready = (!s1_valid || s2_ready) && !rst;
  assign arith    = is_arith(s1_op);
  // Carry comes straight from the flag register, so ADC/SBC in S1 sees every older op's C.
  alu_core #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_core (
    .a(s1_a),
    .b(s1_b),
    .opcode(s1_op),
    .c_in(flags[FLAG_C]),
    .result(c_res),
    .n(c_n),
    .z(c_z),
    .c(c_c),
    .v(c_v),
    .illegal(c_ill)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      illegal   <= 1'b0;
      flags     <= '0;
    end else begin
      if (in_valid && in_ready) begin
        s1_valid <= 1'b1;
        s1_a     <= a;
        s1_b     <= b;
        s1_op    <= opcode;
        s1_sf    <= set_flags;
      end else if (s2_ready) begin
        s1_valid <= 1'b0;
      end
      if (s2_ready) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          result  <= c_res;
          illegal <= c_ill;
          if (s1_sf && !c_ill)
            flags <= {c_n, c_z, arith ? c_c : flags[FLAG_C], arith ? c_v : flags[FLAG_V]};
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe; expected ROR behaviour follows ALU_ROR_EN.
module tb_alu_pipe;
  import alu_pkg::*;
  typedef struct packed {
    logic [31:0] r;
    logic        ill;
    logic [3:0]  f;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        set_flags = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  opcode = '0;
  logic        in_ready;
  logic        out_valid;
  logic        illegal;
  logic [31:0] result;
  logic [3:0]  flags;
  exp_t        sbq[$];
  logic [3:0]  mflags = '0;
  int          checks = 0;
  int          errors = 0;
  int          popped = 0;
  always #5 clk = ~clk;
  alu_pipe #(.WIDTH(32), .SHAMT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .opcode(opcode),
    .set_flags(set_flags),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .flags(flags),
    .illegal(illegal)
  );
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic [3:0] op,
                                 input logic [3:0] f, input logic sf);
    exp_t        e;
    longint      ux = longint'(x);
    longint      uy = longint'(y);
    longint      sx = longint'($signed(x));
    longint      sy = longint'($signed(y));
    longint      cy = longint'(f[1]);
    longint      u = 0;
    longint      s = 0;
    logic [31:0] r = '0;
    logic        ar = 1'b0;
    logic        ok = 1'b1;
    logic        c;
    logic        v;
    int          amt = int'(y[7:0]);
    case (op)
      OP_ADD: begin u = ux + uy; s = sx + sy; ar = 1'b1; end
      OP_SUB: begin u = ux - uy; s = sx - sy; ar = 1'b1; end
      OP_ADC: begin u = ux + uy + cy; s = sx + sy + cy; ar = 1'b1; end
      OP_SBC: begin u = ux - uy - (1 - cy); s = sx - sy - (1 - cy); ar = 1'b1; end
      OP_AND: r = x & y;
      OP_ORR: r = x | y;
      OP_EOR: r = x ^ y;
      OP_MVN: r = ~x;
      OP_LSL: r = amt >= 32 ? 32'h0 : x << amt;
      OP_LSR: r = amt >= 32 ? 32'h0 : x >> amt;
      OP_ASR: r = amt >= 32 ? {32{x[31]}} : 32'($signed(x) >>> amt);
      OP_ROR: begin
`ifdef ALU_ROR_EN
        r = x;
        for (int i = 0; i < amt % 32; i++) r = {r[0], r[31:1]};
`else
        ok = 1'b0;
`endif
      end
      default: ok = 1'b0;
    endcase
    if (ar) r = u[31:0];
    c = (op == OP_SUB || op == OP_SBC) ? (u >= 0) : (u > 64'shFFFFFFFF);
    v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    if (!ok) r = '0;
    e.r = r;
    e.ill = !ok;
    e.f = f;
    if (ok && sf) begin
      e.f[3] = r[31];
      e.f[2] = (r == 32'h0);
      if (ar) begin
        e.f[1] = c;
        e.f[0] = v;
      end
    end
    return e;
  endfunction
  task automatic push();
    exp_t e;
    e = model(a, b, opcode, mflags, set_flags);
    mflags = e.f;
    sbq.push_back(e);
  endtask
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output result=%h illegal=%b flags=%b", result, illegal, flags);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          popped++;
          if (result !== e.r || illegal !== e.ill || flags !== e.f) begin
            errors++;
            $display("FAIL scoreboard got r=%h ill=%b f=%b want r=%h ill=%b f=%b",
                     result, illegal, flags, e.r, e.ill, e.f);
          end
        end
      end
    end
  endtask
  task automatic send(input logic [31:0] xa, input logic [31:0] xb, input logic [3:0] op, input logic sf);
    int   n = 0;
    logic acc = 1'b0;
    a = xa;
    b = xb;
    opcode = op;
    set_flags = sf;
    in_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      if (in_ready) begin
        push();
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout op=%b got in_ready=%b want 1", op, in_ready);
    end
  endtask
  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d want 0", sbq.size());
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", flags); end
    if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b want 0", illegal); end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask
  task automatic test_add_carry();
    out_ready = 1'b1;
    send(32'hFFFFFFFF, 32'h1, OP_ADD, 1'b1);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early got out_valid=%b want 0", out_valid); end
    @(posedge clk);
    #1;
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_valid got %b want 1", out_valid); end
    if (result !== 32'h0) begin errors++; $display("FAIL add_wrap_result got %h want 0", result); end
    if (flags !== 4'b0110) begin errors++; $display("FAIL add_wrap_flags got %b want 0110", flags); end
    drain();
  endtask
  task automatic test_sub_adc();
    send(32'd5, 32'd7, OP_SUB, 1'b1);
    send(32'd1, 32'd1, OP_ADC, 1'b0);
    drain();
    checks += 2;
    if (flags !== 4'b1000) begin errors++; $display("FAIL sub_flags got %b want 1000", flags); end
    if (result !== 32'd2) begin errors++; $display("FAIL adc_result got %h want 2", result); end
  endtask
  task automatic test_overflow();
    send(32'h7FFFFFFF, 32'h1, OP_ADD, 1'b0);
    drain();
    checks += 2;
    if (result !== 32'h80000000) begin errors++; $display("FAIL ovf_result got %h want 80000000", result); end
    if (flags !== 4'b1000) begin errors++; $display("FAIL ovf_noset_flags got %b want 1000", flags); end
    send(32'h7FFFFFFF, 32'h1, OP_ADD, 1'b1);
    drain();
    checks++;
    if (flags !== 4'b1001) begin errors++; $display("FAIL ovf_set_flags got %b want 1001", flags); end
  endtask
  task automatic test_shifts_illegal();
    send(32'h80000000, 32'd40, OP_ASR, 1'b1);
    send(32'hFFFFFFFF, 32'd32, OP_LSL, 1'b1);
    send(32'h12345678, 32'h9, 4'b1101, 1'b1);
    drain();
    checks += 3;
    if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag got %b want 1", illegal); end
    if (result !== 32'h0) begin errors++; $display("FAIL illegal_result got %h want 0", result); end
    if (flags !== 4'b0101) begin errors++; $display("FAIL illegal_flags_held got %b want 0101", flags); end
  endtask
  task automatic test_back_to_back();
    logic [3:0] ops [11];
    logic       done = 1'b0;
    int         p0;
    int         acc = 0;
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_ADC, OP_SBC, OP_LSL, OP_LSR, OP_ASR, OP_MVN};
    p0 = popped;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send($urandom, $urandom, ops[$urandom_range(0, 10)], 1'($urandom_range(0, 1)));
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = $urandom;
    b = $urandom;
    opcode = ops[$urandom_range(0, 10)];
    set_flags = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (in_ready) begin
        push();
        acc++;
      end
      @(posedge clk);
      #1;
      a = $urandom;
      b = $urandom;
      opcode = ops[$urandom_range(0, 10)];
    end
    in_valid = 1'b0;
    checks += 2;
    if (acc != 2) begin errors++; $display("FAIL backpressure_accepts got %0d want 2", acc); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL backpressure_in_ready got %b want 0", in_ready); end
    drain();
    checks++;
    if (popped - p0 != 10) begin errors++; $display("FAIL stream_count got %0d want 10", popped - p0); end
  endtask
  task automatic test_reset_midflight();
    out_ready = 1'b0;
    send(32'hFFFFFFFF, 32'h1, OP_ADD, 1'b1);
    send(32'd3, 32'd4, OP_ADD, 1'b1);
    in_valid = 1'b0;
    rst = 1'b1;
    sbq.delete();
    mflags = '0;
    @(posedge clk);
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid got %b want 0", out_valid); end
    if (flags !== 4'b0000) begin errors++; $display("FAIL midreset_flags got %b want 0000", flags); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL midreset_in_ready got %b want 0", in_ready); end
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL stale_output got out_valid=%b want 0", out_valid); end
  endtask
  task automatic test_ror();
    logic [31:0] want_r;
    logic        want_i;
`ifdef ALU_ROR_EN
    want_r = 32'd5;
    want_i = 1'b0;
`else
    want_r = 32'd0;
    want_i = 1'b1;
`endif
    send(32'h00000001, 32'd1, OP_ROR, 1'b1);
    send(32'h00000005, 32'd32, OP_ROR, 1'b1);
    drain();
    checks += 2;
    if (result !== want_r) begin errors++; $display("FAIL ror_result got %h want %h", result, want_r); end
    if (illegal !== want_i) begin errors++; $display("FAIL ror_illegal got %b want %b", illegal, want_i); end
  endtask
  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_add_carry();
    test_sub_adc();
    test_overflow();
    test_shifts_illegal();
    test_back_to_back();
    test_reset_midflight();
    test_ror();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
